dvs_aer_transmitter: RTL
========================

DVS_AER_TRANSMITTER -- requirements
Module: dvs_aer_transmitter

Interface
REQ-001 Parameter SETUP_CYCLES, default 2: clk cycles that aer/xsel are held stable before req rises (minimum 1).
REQ-002 Parameter ROW_TIMEOUT_CYCLES, default 1000: idle cycles after which the cached row is invalid and Y is resent.
REQ-003 clk  input  1  single clock, rising-edge; all logic in this one domain.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  event present on in_x/in_y/in_polarity.
REQ-006 in_ready  output  1  block accepts an event this cycle.
REQ-007 in_x  input  DVS_X_ADDR_BITS  event column.
REQ-008 in_y  input  DVS_Y_ADDR_BITS  event row.
REQ-009 in_polarity  input  1  event polarity.
REQ-010 aer  output  10  AER data bus.
REQ-011 xsel  output  1  0 = Y word, 1 = X word.
REQ-012 req  output  1  AER request, four-phase.
REQ-013 ack  input  1  AER acknowledge from receiver, asynchronous to clk.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 ack SHALL pass through a 2-flop synchronizer (ack_s); all FSM decisions use ack_s only.
REQ-016 FSM states: IDLE, SETUP_Y, REQ_Y, REL_Y, SETUP_X, REQ_X, REL_X.
REQ-017 in_ready = 1 only in IDLE; an event is accepted on a clk edge with in_valid & in_ready, and in_x/in_y/in_polarity are registered at that edge.
REQ-018 On accept: go to SETUP_Y, unless row_valid & (in_y == last_y), then go to SETUP_X (Y skipped).
REQ-019 Y word: aer = {1'b0, y[8:0]}, xsel = 0; X word: aer = {x[8:0], polarity}, xsel = 1; aer/xsel are registered and change only on entry to SETUP_Y/SETUP_X.
REQ-020 SETUP_x: hold for SETUP_CYCLES cycles and additionally until ack_s = 0; then go to REQ_x.
REQ-021 REQ_x: req = 1; remain until ack_s = 1; then go to REL_x.
REQ-022 REL_x: req = 0; remain until ack_s = 0; REL_Y then goes to SETUP_X, REL_X goes to IDLE.
REQ-023 req SHALL be a registered output, glitch-free, and high only in REQ_x states.
REQ-024 On leaving REL_Y: last_y <= registered y, row_valid <= 1.
REQ-025 Row idle counter: cleared on each accept; incremented each IDLE cycle, saturating at ROW_TIMEOUT_CYCLES; on reaching it, row_valid <= 0.
REQ-026 Accept in the same cycle the counter reaches the timeout: the timeout wins, so Y is sent.
REQ-027 Back-to-back events: earliest accept is the cycle after REL_X exits; no event is ever dropped or reordered.
REQ-028 No handshake timeout: the FSM waits indefinitely on ack_s; aer/xsel stay stable throughout REQ_x/REL_x.

Reset
REQ-029 Reset values: state = IDLE, req = 0, aer = 0, xsel = 0, in_ready = 1 after reset, busy = 0, row_valid = 0, counter = 0, synchronizer flops = 0.
REQ-030 Reset mid-handshake: req drops immediately (asynchronously); the in-flight event is discarded; the next event always sends Y.

Structure
REQ-031 dvs_ravens_pkg holds DVS_X_ADDR_BITS, DVS_Y_ADDR_BITS, DVS_WIDTH_PXLS, DVS_HEIGHT_PXLS, CLK_PERIOD_NS, and the new FSM state enum type aer_tx_state_t.
REQ-032 The synchronizer is a separate sub-module, sync_2ff, reusable by dvs_aer_receiver.
REQ-033 Loopback bench: dvs_aer_transmitter.aer/xsel/req/ack connect directly to dvs_aer_receiver.

Verification
REQ-034 Reset, then event (x=0x12, y=0x34, p=1): Y word 0x034/xsel=0 appears, req rises 2 cycles later, then X word 0x025/xsel=1; in the loopback bench the receiver outputs event_x=0x12, event_y=0x34.
REQ-035 Second event with y=0x34 within 100 cycles: no Y word is sent, only X; with ROW_TIMEOUT_CYCLES=100 and a gap of 150 cycles, Y is resent.
REQ-036 Responder delays ack by 0-20 random cycles on both edges: aer/xsel are stable whenever req=1, and no req rises while ack_s=1.
REQ-037 ack held high at accept: req stays 0 until ack falls, then SETUP completes and req rises.
REQ-038 Assert rst_n=0 while req=1: req=0 within 1 ns, in_ready=1 after release, and the next event (same y) sends Y.
REQ-039 Stream of 1000 random events, in_valid held high: receiver output sequence matches input order exactly, with in_ready high only in IDLE.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// -----------------------------------------------------------------------------
// dvs_ravens_pkg
//   Shared constants for the DVS sensor interface blocks, plus the state type
//   of the AER transmitter FSM and helpers that build the two AER bus words.
//
//   Y word : {1'b0, y[8:0]}          sent with xsel = 0
//   X word : {x[8:0], polarity}      sent with xsel = 1
// -----------------------------------------------------------------------------
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS = 9;
  localparam int DVS_Y_ADDR_BITS = 9;
  localparam int DVS_WIDTH_PXLS  = 346;
  localparam int DVS_HEIGHT_PXLS = 260;
  localparam int CLK_PERIOD_NS   = 10;
  localparam int AER_BUS_BITS    = 10;

  typedef enum logic [2:0] {
    AER_TX_IDLE    = 3'd0,
    AER_TX_SETUP_Y = 3'd1,
    AER_TX_REQ_Y   = 3'd2,
    AER_TX_REL_Y   = 3'd3,
    AER_TX_SETUP_X = 3'd4,
    AER_TX_REQ_X   = 3'd5,
    AER_TX_REL_X   = 3'd6
  } aer_tx_state_t;

  function automatic logic [AER_BUS_BITS-1:0] aer_y_word(
    input logic [DVS_Y_ADDR_BITS-1:0] y
  );
    return {1'b0, y[8:0]};
  endfunction

  function automatic logic [AER_BUS_BITS-1:0] aer_x_word(
    input logic [DVS_X_ADDR_BITS-1:0] x,
    input logic                       polarity
  );
    return {x[8:0], polarity};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for slowly changing asynchronous level signals
//   (handshake lines). Both flops reset to 0.
//
//   clk   in   destination clock
//   rst_n in   asynchronous active-low reset
//   d     in   asynchronous input
//   q     out  synchronized copy of d, two clk edges later
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dvs_aer_transmitter.sv
// -----------------------------------------------------------------------------
// dvs_aer_transmitter
//   Sends DVS events over a four-phase AER link as a row (Y) word followed by
//   a column/polarity (X) word. The last row sent is cached; a following
//   event on the same row sends only the X word, unless the link has been
//   idle for ROW_TIMEOUT_CYCLES, after which the row is resent.
//
//   Input handshake: an event transfers on a rising clk edge where
//   in_valid & in_ready are both 1; in_ready is 1 only while the FSM is idle.
//   AER handshake: aer/xsel settle for SETUP_CYCLES (and until ack is low),
//   then req rises; req falls after ack rises; the word is done when ack falls.
//
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   event input handshake
//   in_x/in_y/in_polarity  event column, row, polarity
//   aer, xsel           AER data bus and word select (0 = Y, 1 = X)
//   req                 AER request (registered, high only in REQ states)
//   ack                 AER acknowledge, asynchronous to clk
//   busy                high whenever the FSM is not idle
//   state_dbg           current FSM state
// -----------------------------------------------------------------------------
module dvs_aer_transmitter
  import dvs_ravens_pkg::*;
#(
  parameter int SETUP_CYCLES       = 2,
  parameter int ROW_TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DVS_X_ADDR_BITS-1:0] in_x,
  input  logic [DVS_Y_ADDR_BITS-1:0] in_y,
  input  logic                       in_polarity,
  output logic [AER_BUS_BITS-1:0]    aer,
  output logic                       xsel,
  output logic                       req,
  input  logic                       ack,
  output logic                       busy,
  output aer_tx_state_t              state_dbg
);

  localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int CNT_W   = $clog2(ROW_TIMEOUT_CYCLES + 1);

  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);
  localparam logic [SETUP_W-1:0] SETUP_ONE  = SETUP_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(ROW_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(ROW_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  aer_tx_state_t              state;
  logic                       ack_s;
  logic [SETUP_W-1:0]         setup_cnt;
  logic [CNT_W-1:0]           idle_cnt;
  logic                       row_valid;
  logic                       row_hit;
  logic [DVS_Y_ADDR_BITS-1:0] last_y;
  logic [DVS_X_ADDR_BITS-1:0] x_reg;
  logic [DVS_Y_ADDR_BITS-1:0] y_reg;
  logic                       pol_reg;

  sync_2ff #(
    .WIDTH (1)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack),
    .q     (ack_s)
  );

  assign in_ready  = (state == AER_TX_IDLE);
  assign busy      = (state != AER_TX_IDLE);
  assign state_dbg = state;

  // The idle cycle in which the counter would reach the timeout already
  // counts as expired, so an accept in that cycle resends the row.
  assign row_hit = row_valid && (in_y == last_y) && (idle_cnt < CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= AER_TX_IDLE;
      req       <= 1'b0;
      aer       <= '0;
      xsel      <= 1'b0;
      setup_cnt <= '0;
      idle_cnt  <= '0;
      row_valid <= 1'b0;
      last_y    <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      pol_reg   <= 1'b0;
    end else begin
      unique case (state)
        AER_TX_IDLE: begin
          if (in_valid) begin
            x_reg     <= in_x;
            y_reg     <= in_y;
            pol_reg   <= in_polarity;
            idle_cnt  <= '0;
            setup_cnt <= '0;
            if (row_hit) begin
              state <= AER_TX_SETUP_X;
              aer   <= aer_x_word(in_x, in_polarity);
              xsel  <= 1'b1;
            end else begin
              state <= AER_TX_SETUP_Y;
              aer   <= aer_y_word(in_y);
              xsel  <= 1'b0;
            end
          end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + CNT_ONE;
            if (idle_cnt == CNT_LAST) row_valid <= 1'b0;
          end
        end

        AER_TX_SETUP_Y, AER_TX_SETUP_X: begin
          // Hold the word for the full setup time, then also wait out any
          // ack still high from a previous handshake before requesting.
          if (setup_cnt != SETUP_LAST) begin
            setup_cnt <= setup_cnt + SETUP_ONE;
          end else if (!ack_s) begin
            req   <= 1'b1;
            state <= (state == AER_TX_SETUP_Y) ? AER_TX_REQ_Y : AER_TX_REQ_X;
          end
        end

        AER_TX_REQ_Y, AER_TX_REQ_X: begin
          if (ack_s) begin
            req   <= 1'b0;
            state <= (state == AER_TX_REQ_Y) ? AER_TX_REL_Y : AER_TX_REL_X;
          end
        end

        AER_TX_REL_Y: begin
          if (!ack_s) begin
            last_y    <= y_reg;
            row_valid <= 1'b1;
            setup_cnt <= '0;
            aer       <= aer_x_word(x_reg, pol_reg);
            xsel      <= 1'b1;
            state     <= AER_TX_SETUP_X;
          end
        end

        AER_TX_REL_X: begin
          if (!ack_s) state <= AER_TX_IDLE;
        end

        default: begin
          req   <= 1'b0;
          state <= AER_TX_IDLE;
        end
      endcase
    end
  end

endmodule
